// File: rtl/tile_cache_pkg.sv
// -----------------------------------------------------------------------------
// tile_cache_pkg
// Shared definitions for the tile/sprite ROM read cache:
//   - state_t     : controller FSM encoding
//   - tag_width() : tag bits left over once the index is taken from the address
//   - ways_legal(): only direct-mapped (1) and 2-way organisations exist
// -----------------------------------------------------------------------------
package tile_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_RESP,
        ST_FLUSH
    } state_t;

    function automatic int tag_width(input int aw, input int iw);
        return aw - iw;
    endfunction

    function automatic bit ways_legal(input int ways);
        return (ways == 1) || (ways == 2);
    endfunction

endpackage

// File: rtl/tile_cache_assoc_way.sv
// -----------------------------------------------------------------------------
// cache_way
// One way of the tile cache: a {valid, tag} RAM and a data RAM, both
// 2**IW deep, sharing one synchronous read port and one write port.
// Ports:
//   clk        : clock
//   i_rd_idx   : set index to read; results appear one cycle later
//   o_rd_valid : registered valid bit of the read set
//   o_rd_tag   : registered tag of the read set
//   o_rd_data  : registered data word of the read set
//   i_wr_en    : write enable (tag, valid and data written together)
//   i_wr_idx   : set index to write
//   i_wr_valid : valid bit to store (0 when invalidating)
//   i_wr_tag   : tag to store
//   i_wr_data  : data word to store
// -----------------------------------------------------------------------------
module cache_way #(
    parameter int TW = 8,
    parameter int DW = 32,
    parameter int IW = 10
) (
    input  logic          clk,
    input  logic [IW-1:0] i_rd_idx,
    output logic          o_rd_valid,
    output logic [TW-1:0] o_rd_tag,
    output logic [DW-1:0] o_rd_data,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic          i_wr_valid,
    input  logic [TW-1:0] i_wr_tag,
    input  logic [DW-1:0] i_wr_data
);

    // Bit TW is the valid flag, bits TW-1:0 the tag.
    logic [TW:0]   r_tag_mem  [2**IW];
    logic [DW-1:0] r_data_mem [2**IW];
    logic [TW:0]   r_tag_q;
    logic [DW-1:0] r_data_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_idx]  <= {i_wr_valid, i_wr_tag};
            r_data_mem[i_wr_idx] <= i_wr_data;
        end
        r_tag_q  <= r_tag_mem[i_rd_idx];
        r_data_q <= r_data_mem[i_rd_idx];
    end

    assign o_rd_valid = r_tag_q[TW];
    assign o_rd_tag   = r_tag_q[TW-1:0];
    assign o_rd_data  = r_data_q;

endmodule

// File: rtl/tile_cache_assoc.sv
// -----------------------------------------------------------------------------
// tile_cache_assoc
// Read-only set-associative cache (1 or 2 ways, per-set LRU) sitting between
// the tile/sprite renderers and the SDRAM ROM port. Every set is invalidated
// by a flush walk after reset and on request.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   flush       : one-cycle request to invalidate all sets
//   busy        : high while the flush walk runs (requests not accepted)
//   cache_req   : level request, cache_addr stable while high
//   cache_addr  : requested word address
//   cache_valid : one-cycle pulse, cache_data holds the requested word
//   cache_data  : registered read data
//   rom_req     : level request to SDRAM, rom_addr stable while high
//   rom_addr    : SDRAM word address
//   rom_data    : SDRAM data, sampled only with rom_valid in FILL
//   rom_valid   : SDRAM data strobe
// -----------------------------------------------------------------------------
module tile_cache_assoc
    import tile_cache_pkg::*;
#(
    parameter int AW   = 18,
    parameter int DW   = 32,
    parameter int IW   = 10,
    parameter int WAYS = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    output logic          busy,
    input  logic          cache_req,
    input  logic [AW-1:0] cache_addr,
    output logic          cache_valid,
    output logic [DW-1:0] cache_data,
    output logic          rom_req,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_valid
);

    localparam int TW = tag_width(AW, IW);
    // An unsupported WAYS value falls back to a direct-mapped cache.
    localparam int NW = ways_legal(WAYS) ? WAYS : 1;

    state_t           r_state;
    logic [AW-1:0]    r_addr;
    logic [IW-1:0]    r_flush_cnt;
    logic             r_flush_pend;
    logic [2**IW-1:0] r_lru;          // per set: the way to replace next
    logic             r_victim;
    logic             r_busy;
    logic             r_cache_valid;
    logic [DW-1:0]    r_cache_data;
    logic             r_rom_req;
    logic [AW-1:0]    r_rom_addr;

    logic [IW-1:0]    w_idx;
    logic [TW-1:0]    w_tag;
    logic [IW-1:0]    w_rd_idx;
    logic [IW-1:0]    w_wr_idx;
    logic             w_fill_wr;
    logic             w_flush_wr;
    logic [NW-1:0]    w_rd_valid;
    logic [TW-1:0]    w_rd_tag  [NW];
    logic [DW-1:0]    w_rd_data [NW];
    logic [NW-1:0]    w_hit;
    logic [NW-1:0]    w_wr_en;
    logic             w_hit_any;
    logic             w_hit_way;
    logic [DW-1:0]    w_hit_data;
    logic             w_victim;

    assign w_idx = r_addr[IW-1:0];
    assign w_tag = r_addr[AW-1:IW];

    // In IDLE the RAMs are addressed straight from the request so that the
    // tags are ready in LOOKUP; otherwise they keep reading the held set.
    assign w_rd_idx = (r_state == ST_IDLE) ? cache_addr[IW-1:0] : w_idx;

    // Writes are suppressed under reset so a fill abandoned by reset can
    // never leave a tag behind.
    assign w_fill_wr  = (r_state == ST_FILL) && rom_valid && !reset;
    assign w_flush_wr = (r_state == ST_FLUSH) && !reset;
    assign w_wr_idx   = w_flush_wr ? r_flush_cnt : w_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_way
            assign w_hit[gi]   = w_rd_valid[gi] && (w_rd_tag[gi] == w_tag);
            assign w_wr_en[gi] = w_flush_wr || (w_fill_wr && (int'(r_victim) == gi));

            cache_way #(
                .TW (TW),
                .DW (DW),
                .IW (IW)
            ) u_way (
                .clk        (clk),
                .i_rd_idx   (w_rd_idx),
                .o_rd_valid (w_rd_valid[gi]),
                .o_rd_tag   (w_rd_tag[gi]),
                .o_rd_data  (w_rd_data[gi]),
                .i_wr_en    (w_wr_en[gi]),
                .i_wr_idx   (w_wr_idx),
                .i_wr_valid (w_fill_wr),
                .i_wr_tag   (w_tag),
                .i_wr_data  (rom_data)
            );
        end
    endgenerate

    // Hit way/data select and victim choice (first invalid way, else LRU).
    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_way  = 1'b0;
        w_hit_data = '0;
        for (int w = 0; w < NW; w++) begin
            if (w_hit[w]) begin
                w_hit_any  = 1'b1;
                w_hit_way  = 1'(w);
                w_hit_data = w_rd_data[w];
            end
        end
        if (NW == 1)
            w_victim = 1'b0;
        else if (!w_rd_valid[0])
            w_victim = 1'b0;
        else if (!w_rd_valid[NW-1])
            w_victim = 1'b1;
        else
            w_victim = r_lru[w_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_FLUSH;
            r_busy        <= 1'b1;
            r_flush_cnt   <= '0;
            r_flush_pend  <= 1'b0;
            r_lru         <= '0;
            r_addr        <= '0;
            r_victim      <= 1'b0;
            r_cache_valid <= 1'b0;
            r_cache_data  <= '0;
            r_rom_req     <= 1'b0;
            r_rom_addr    <= '0;
        end else begin
            r_cache_valid <= 1'b0;
            if (flush)
                r_flush_pend <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (flush || r_flush_pend) begin
                        r_state      <= ST_FLUSH;
                        r_busy       <= 1'b1;
                        r_flush_cnt  <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (cache_req) begin
                        r_addr  <= cache_addr;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit_any) begin
                        r_cache_data <= w_hit_data;
                        if (NW == 2)
                            r_lru[w_idx] <= ~w_hit_way;
                        r_state <= ST_RESP;
                    end else begin
                        r_rom_req  <= 1'b1;
                        r_rom_addr <= r_addr;
                        r_victim   <= w_victim;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (rom_valid) begin
                        r_rom_req    <= 1'b0;
                        r_cache_data <= rom_data;
                        if (NW == 2)
                            r_lru[w_idx] <= ~r_victim;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_cache_valid <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                ST_FLUSH: begin
                    r_lru[r_flush_cnt] <= 1'b0;
                    // A flush request during the walk restarts it from set 0.
                    r_flush_pend <= 1'b0;
                    if (flush) begin
                        r_flush_cnt <= '0;
                    end else if (&r_flush_cnt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_FLUSH;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign cache_valid = r_cache_valid;
    assign cache_data  = r_cache_data;
    assign rom_req     = r_rom_req;
    assign rom_addr    = r_rom_addr;

endmodule

// File: tb/tb_tile_cache_assoc.sv
// -----------------------------------------------------------------------------
// tb_tile_cache_assoc
// Directed bench for the tile cache. Instance 0 is 2-way, instance 1 is
// direct-mapped; both use AW=18, DW=32, IW=10 and share clock and reset.
// Outputs are sampled on the falling edge, inputs driven there too.
// -----------------------------------------------------------------------------
module tb_tile_cache_assoc;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int IW = 10;
    localparam int SETS = 2**IW;

    logic          clk;
    logic          reset;
    logic          flush       [2];
    logic          busy        [2];
    logic          req         [2];
    logic [AW-1:0] addr        [2];
    logic          cache_valid [2];
    logic [DW-1:0] cache_data  [2];
    logic          rom_req     [2];
    logic [AW-1:0] rom_addr    [2];
    logic [DW-1:0] rom_data    [2];
    logic          rom_valid   [2];

    int n_checks = 0;
    int n_errors = 0;

    tile_cache_assoc #(.AW(AW), .DW(DW), .IW(IW), .WAYS(2)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush[0]),
        .busy        (busy[0]),
        .cache_req   (req[0]),
        .cache_addr  (addr[0]),
        .cache_valid (cache_valid[0]),
        .cache_data  (cache_data[0]),
        .rom_req     (rom_req[0]),
        .rom_addr    (rom_addr[0]),
        .rom_data    (rom_data[0]),
        .rom_valid   (rom_valid[0])
    );

    tile_cache_assoc #(.AW(AW), .DW(DW), .IW(IW), .WAYS(1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush[1]),
        .busy        (busy[1]),
        .cache_req   (req[1]),
        .cache_addr  (addr[1]),
        .cache_valid (cache_valid[1]),
        .cache_data  (cache_data[1]),
        .rom_req     (rom_req[1]),
        .rom_addr    (rom_addr[1]),
        .rom_data    (rom_data[1]),
        .rom_valid   (rom_valid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One read transaction on instance s. The SDRAM model answers rom_lat
    // falling edges after it first sees rom_req, and otherwise drives junk
    // on rom_data. Optionally pulses flush when the fill starts.
    task automatic do_read(input int s, input logic [AW-1:0] a, input logic [DW-1:0] word,
                           input int rom_lat, input bit pulse_flush,
                           output logic [DW-1:0] data, output int lat,
                           output int n_miss, output int busy_seen);
        int  wait_c;
        bit  prev_req;
        bit  done;
        data = '0; lat = -1; n_miss = 0; busy_seen = 0;
        wait_c = -1; prev_req = 1'b0; done = 1'b0;
        req[s]  = 1'b1;
        addr[s] = a;
        for (int c = 1; c <= 4000 && !done; c++) begin
            @(negedge clk);
            flush[s] = 1'b0;
            if (rom_valid[s]) begin
                rom_valid[s] = 1'b0;
                rom_data[s]  = ~word;
            end
            if (busy[s])
                busy_seen++;
            if (rom_req[s] && !prev_req) begin
                n_miss++;
                wait_c = 0;
                check("rom_addr", 64'(rom_addr[s]), 64'(a));
                if (pulse_flush)
                    flush[s] = 1'b1;
            end else if (rom_req[s] && wait_c >= 0) begin
                wait_c++;
                if (wait_c == rom_lat) begin
                    rom_valid[s] = 1'b1;
                    rom_data[s]  = word;
                end
            end
            prev_req = rom_req[s];
            if (cache_valid[s]) begin
                data = cache_data[s];
                lat  = c;
                done = 1'b1;
            end
        end
        req[s] = 1'b0;
        if (!done)
            check("read_timeout", 64'(0), 64'(1));
        $display("read inst%0d addr=0x%05h data=0x%08h lat=%0d misses=%0d busy=%0d",
                 s, a, data, lat, n_miss, busy_seen);
    endtask

    logic [DW-1:0] d;
    int lat, nm, bs;
    int b0, b1, pulses;

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            flush[s] = 1'b0; req[s] = 1'b0; addr[s] = '0;
            rom_data[s] = '0; rom_valid[s] = 1'b0;
        end

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cache_valid", 64'(cache_valid[0]), 64'(0));
        check("rst_rom_req",     64'(rom_req[0]),     64'(0));
        check("rst_rom_addr",    64'(rom_addr[0]),    64'(0));
        check("rst_cache_data",  64'(cache_data[0]),  64'(0));
        check("rst_busy",        64'(busy[0]),        64'(1));

        // Post-reset flush walk: busy for exactly SETS cycles.
        reset = 1'b0;
        b0 = 0; b1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (busy[0]) b0++;
            if (busy[1]) b1++;
            if (!busy[0] && !busy[1]) break;
            @(negedge clk);
        end
        check("busy_len_2way", 64'(b0), 64'(SETS));
        check("busy_len_1way", 64'(b1), 64'(SETS));

        // 2-way: first read misses, SDRAM answers after 5 cycles.
        do_read(0, 18'h00123, 32'hDEADBEEF, 5, 1'b0, d, lat, nm, bs);
        check("miss1_data",  64'(d),  64'(32'hDEADBEEF));
        check("miss1_count", 64'(nm), 64'(1));
        check("miss1_romreq_drop", 64'(rom_req[0]), 64'(0));

        // Re-read hits: no SDRAM access, valid on the third edge.
        do_read(0, 18'h00123, 32'h11111111, 5, 1'b0, d, lat, nm, bs);
        check("hit1_data",  64'(d),   64'(32'hDEADBEEF));
        check("hit1_count", 64'(nm),  64'(0));
        check("hit1_lat",   64'(lat), 64'(3));

        // Same index, new tags: 0x523 fills way 1, 0x923 evicts LRU 0x123.
        do_read(0, 18'h00523, 32'h55555523, 2, 1'b0, d, lat, nm, bs);
        check("w2_523_miss", 64'(nm), 64'(1));
        check("w2_523_data", 64'(d),  64'(32'h55555523));
        do_read(0, 18'h00923, 32'h99999923, 1, 1'b0, d, lat, nm, bs);
        check("w2_923_miss", 64'(nm), 64'(1));
        check("w2_923_data", 64'(d),  64'(32'h99999923));
        do_read(0, 18'h00523, 32'h0, 1, 1'b0, d, lat, nm, bs);
        check("w2_523_hit",  64'(nm), 64'(0));
        check("w2_523_hdat", 64'(d),  64'(32'h55555523));
        do_read(0, 18'h00123, 32'hDEADBEEF, 3, 1'b0, d, lat, nm, bs);
        check("w2_123_evicted", 64'(nm), 64'(1));
        check("w2_123_data",    64'(d),  64'(32'hDEADBEEF));
        // 0x123 replaced 0x923 (LRU after the 0x523 hit), so 0x523 survives.
        do_read(0, 18'h00523, 32'h0, 1, 1'b0, d, lat, nm, bs);
        check("w2_523_kept", 64'(nm), 64'(0));

        // Direct-mapped: 0x523 evicts 0x123 immediately.
        do_read(1, 18'h00123, 32'hDEADBEEF, 4, 1'b0, d, lat, nm, bs);
        check("w1_123_miss", 64'(nm), 64'(1));
        do_read(1, 18'h00523, 32'h55555523, 4, 1'b0, d, lat, nm, bs);
        check("w1_523_miss", 64'(nm), 64'(1));
        do_read(1, 18'h00123, 32'hDEADBEEF, 4, 1'b0, d, lat, nm, bs);
        check("w1_123_remiss", 64'(nm), 64'(1));
        check("w1_123_data",   64'(d),  64'(32'hDEADBEEF));
        do_read(1, 18'h00123, 32'h0, 4, 1'b0, d, lat, nm, bs);
        check("w1_123_hit", 64'(nm), 64'(0));

        // Flush during a fill: data still returned, then the walk runs while
        // the next request waits, and that request misses.
        do_read(0, 18'h3FFFF, 32'h0BADF00D, 3, 1'b1, d, lat, nm, bs);
        check("fl_fill_data", 64'(d),  64'(32'h0BADF00D));
        check("fl_fill_miss", 64'(nm), 64'(1));
        do_read(0, 18'h3FFFF, 32'hC0FFEE00, 2, 1'b0, d, lat, nm, bs);
        check("fl_busy_len",   64'(bs), 64'(SETS));
        check("fl_after_miss", 64'(nm), 64'(1));
        check("fl_after_data", 64'(d),  64'(32'hC0FFEE00));

        // Reset while a fill is outstanding, late rom_valid two cycles on.
        req[0] = 1'b1; addr[0] = 18'h01234;
        b0 = 0;
        for (int c = 0; c < 20 && !rom_req[0]; c++) begin
            @(negedge clk);
            b0++;
        end
        check("rst_fill_started", 64'(rom_req[0]), 64'(1));
        reset = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        check("rst_fill_romreq", 64'(rom_req[0]), 64'(0));
        check("rst_fill_busy",   64'(busy[0]),    64'(1));
        reset = 1'b0;
        @(negedge clk);
        rom_valid[0] = 1'b1; rom_data[0] = 32'h77777777;
        @(negedge clk);
        rom_valid[0] = 1'b0; rom_data[0] = '0;
        pulses = 0;
        for (int c = 0; c < 3000 && (busy[0] || busy[1]); c++) begin
            if (cache_valid[0]) pulses++;
            @(negedge clk);
        end
        check("rst_fill_no_valid", 64'(pulses),  64'(0));
        check("rst_fill_walk_end", 64'(busy[0]), 64'(0));
        do_read(0, 18'h01234, 32'h12341234, 2, 1'b0, d, lat, nm, bs);
        check("rst_fill_remiss", 64'(nm), 64'(1));
        check("rst_fill_data",   64'(d),  64'(32'h12341234));
        do_read(0, 18'h00523, 32'h52352352, 2, 1'b0, d, lat, nm, bs);
        check("rst_cleared_523", 64'(nm), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
